// File: rtl/dma_reg_pkg.sv
// Shared register map, bit positions and channel state type for the DMA register bank.
package dma_reg_pkg;

  localparam logic [4:0] OFF_SRC    = 5'h00;
  localparam logic [4:0] OFF_DST    = 5'h04;
  localparam logic [4:0] OFF_LEN    = 5'h08;
  localparam logic [4:0] OFF_CTRL   = 5'h0C;
  localparam logic [4:0] OFF_STATUS = 5'h10;
  localparam logic [4:0] OFF_REMAIN = 5'h14;

  localparam logic [31:0] GLOBAL_BASE     = 32'h0000_0400;
  localparam logic [31:0] ADDR_IRQ_STATUS = GLOBAL_BASE;
  localparam logic [31:0] ADDR_ID         = GLOBAL_BASE + 32'h4;

  localparam int CTRL_START  = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;

  localparam logic [7:0] ID_TAG = 8'hD0;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } ch_state_e;

  function automatic logic [31:0] id_word(input int num_ch, input int beat_bytes);
    logic [7:0]  n;
    logic [15:0] b;
    n = num_ch[7:0];
    b = beat_bytes[15:0];
    return {ID_TAG, n, b};
  endfunction

endpackage

// File: rtl/dma_reg_channel.sv
// One DMA channel: descriptor registers, W1C status and the IDLE/BUSY progress machine.
module dma_reg_channel
  import dma_reg_pkg::*;
#(
  parameter int BEAT_BYTES = 4,
  parameter int LEN_W      = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_wr,
  input  logic [4:0]  i_off,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_wr_reject,
  output logic        o_irq
);

  localparam logic [LEN_W:0] BEAT = (LEN_W + 1)'(BEAT_BYTES);

  ch_state_e          r_state;
  logic [31:0]        r_src;
  logic [31:0]        r_dst;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_remain;
  logic               r_irq_en;
  logic               r_done;
  logic               r_err;

  logic w_busy;
  logic w_wr_cfg;
  logic w_wr_ctrl;
  logic w_wr_stat;
  logic w_start;
  logic w_abort;
  logic w_cfg_ok;
  logic w_last_beat;
  logic w_done_nxt;
  logic w_err_nxt;

  assign w_busy      = (r_state == BUSY);
  assign w_wr_cfg    = i_wr && ((i_off == OFF_SRC) || (i_off == OFF_DST) || (i_off == OFF_LEN));
  assign w_wr_ctrl   = i_wr && (i_off == OFF_CTRL);
  assign w_wr_stat   = i_wr && (i_off == OFF_STATUS);
  assign w_start     = w_wr_ctrl && i_wdata[CTRL_START];
  assign w_abort     = w_wr_ctrl && i_wdata[CTRL_ABORT];
  assign w_cfg_ok    = (r_len != '0) && (r_src[1:0] == 2'b00) && (r_dst[1:0] == 2'b00);
  assign w_last_beat = ({1'b0, r_remain} <= BEAT);

  // Descriptor writes and START are refused while a transfer is in flight.
  assign o_wr_reject = w_busy && (w_wr_cfg || w_start);
  assign o_irq       = r_done && r_irq_en;

  // Software clears are applied first so a same-cycle hardware set wins.
  always_comb begin
    w_done_nxt = r_done;
    w_err_nxt  = r_err;
    if (w_wr_stat && i_wdata[STAT_DONE]) w_done_nxt = 1'b0;
    if (w_wr_stat && i_wdata[STAT_ERR])  w_err_nxt  = 1'b0;
    if (!w_busy && w_start) begin
      if (w_cfg_ok) w_done_nxt = 1'b0;
      else          w_err_nxt  = 1'b1;
    end
    if (w_busy) begin
      if (w_abort)          w_err_nxt  = 1'b1;
      else if (w_last_beat) w_done_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_src    <= '0;
      r_dst    <= '0;
      r_len    <= '0;
      r_irq_en <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (i_wr && !w_busy) begin
        if (i_off == OFF_SRC) r_src <= i_wdata;
        if (i_off == OFF_DST) r_dst <= i_wdata;
        if (i_off == OFF_LEN) r_len <= i_wdata[LEN_W-1:0];
      end
      if (w_wr_ctrl) r_irq_en <= i_wdata[CTRL_IRQ_EN];
      r_done <= w_done_nxt;
      r_err  <= w_err_nxt;
    end
  end

  // ABORT takes priority over the beat, so REMAIN freezes at its current value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_remain <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start && w_cfg_ok) begin
            r_remain <= r_len;
            r_state  <= BUSY;
          end
        end
        BUSY: begin
          if (w_abort) begin
            r_state <= IDLE;
          end else if (w_last_beat) begin
            r_remain <= '0;
            r_state  <= IDLE;
          end else begin
            r_remain <= r_remain - BEAT[LEN_W-1:0];
          end
        end
      endcase
    end
  end

  always_comb begin
    o_rdata = '0;
    case (i_off)
      OFF_SRC:    o_rdata = r_src;
      OFF_DST:    o_rdata = r_dst;
      OFF_LEN:    o_rdata = 32'(r_len);
      OFF_CTRL:   o_rdata[CTRL_IRQ_EN] = r_irq_en;
      OFF_STATUS: begin
        o_rdata[STAT_BUSY] = w_busy;
        o_rdata[STAT_DONE] = r_done;
        o_rdata[STAT_ERR]  = r_err;
      end
      OFF_REMAIN: o_rdata = 32'(r_remain);
      default:    o_rdata = '0;
    endcase
  end

endmodule

// File: rtl/dma_reg_bank.sv
// Multi-channel DMA register bank: address decode, registered read path, error pulse and irq.
module dma_reg_bank
  import dma_reg_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int BEAT_BYTES = 4,
  parameter int LEN_W      = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        wr_en,
  input  logic        valid,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        err,
  output logic        irq
);

  localparam logic [31:0] ID_VALUE = id_word(NUM_CH, BEAT_BYTES);

  logic [4:0]        w_ch_idx;
  logic [4:0]        w_off;
  logic              w_ch_space;
  logic              w_ch_hit;
  logic              w_glb_irq;
  logic              w_glb_id;
  logic              w_mapped;
  logic              w_wr;
  logic              w_reject;
  logic              w_unused_addr;
  logic [NUM_CH-1:0] w_ch_wr;
  logic [NUM_CH-1:0] w_ch_reject;
  logic [NUM_CH-1:0] w_ch_irq;
  logic [31:0]       w_ch_rdata [NUM_CH];
  logic [31:0]       w_rd_mux;

  logic [31:0] r_rdata;
  logic        r_rvalid;
  logic        r_err;

  // Byte lane bits carry no meaning on this bus.
  assign w_unused_addr = ^addr[1:0];

  assign w_ch_space = (addr[31:10] == '0);
  assign w_ch_idx   = addr[9:5];
  assign w_off      = {addr[4:2], 2'b00};
  assign w_ch_hit   = w_ch_space && (32'(w_ch_idx) < NUM_CH) && (w_off <= OFF_REMAIN);
  assign w_glb_irq  = (addr[31:2] == ADDR_IRQ_STATUS[31:2]);
  assign w_glb_id   = (addr[31:2] == ADDR_ID[31:2]);
  assign w_mapped   = w_ch_hit || w_glb_irq || w_glb_id;
  assign w_wr       = valid && wr_en;
  assign w_reject   = |w_ch_reject;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign w_ch_wr[c] = w_wr && w_ch_hit && (w_ch_idx == 5'(c));

    dma_reg_channel #(
      .BEAT_BYTES (BEAT_BYTES),
      .LEN_W      (LEN_W)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .i_wr        (w_ch_wr[c]),
      .i_off       (w_off),
      .i_wdata     (wdata),
      .o_rdata     (w_ch_rdata[c]),
      .o_wr_reject (w_ch_reject[c]),
      .o_irq       (w_ch_irq[c])
    );
  end

  always_comb begin
    w_rd_mux = '0;
    if (w_ch_hit) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_ch_idx == 5'(c)) w_rd_mux = w_ch_rdata[c];
      end
    end
    if (w_glb_irq) w_rd_mux = 32'(w_ch_irq);
    if (w_glb_id)  w_rd_mux = ID_VALUE;
  end

  // rdata holds its last value between reads; only rvalid marks it fresh.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= valid && !wr_en;
      r_err    <= valid && (!w_mapped || (wr_en && w_reject));
      if (valid && !wr_en) r_rdata <= w_rd_mux;
    end
  end

  assign rdata  = r_rdata;
  assign rvalid = r_rvalid;
  assign err    = r_err;
  assign irq    = |w_ch_irq;

endmodule

// File: tb/tb_dma_reg_bank.sv
// Bench for dma_reg_bank: directed vector table, multi-cycle sequences and random traffic vs a model.
module tb_dma_reg_bank;

  localparam int NUM_CH = 4;
  localparam int BEAT   = 4;
  localparam int LEN_W  = 16;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr  = '0;
  logic [31:0] wdata = '0;
  logic        wr_en = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] rdata;
  logic        rvalid;
  logic        err;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  dma_reg_bank #(
    .NUM_CH     (NUM_CH),
    .BEAT_BYTES (BEAT),
    .LEN_W      (LEN_W)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .wr_en  (wr_en),
    .valid  (valid),
    .wdata  (wdata),
    .rdata  (rdata),
    .rvalid (rvalid),
    .err    (err),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  // Reference model: a transfer is described by its start edge and length;
  // progress is computed in closed form rather than stepped.
  logic [31:0] m_src  [NUM_CH];
  logic [31:0] m_dst  [NUM_CH];
  int          m_len  [NUM_CH];
  bit          m_ien  [NUM_CH];
  bit          m_done [NUM_CH];
  bit          m_errf [NUM_CH];
  bit          m_act  [NUM_CH];
  int          m_ts   [NUM_CH];
  int          m_len0 [NUM_CH];
  int          m_nb   [NUM_CH];
  int          m_rem  [NUM_CH];
  int          m_t = 0;

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_src[c] = '0; m_dst[c] = '0; m_len[c] = 0;
      m_ien[c] = 0; m_done[c] = 0; m_errf[c] = 0; m_act[c] = 0;
      m_ts[c] = 0; m_len0[c] = 0; m_nb[c] = 0; m_rem[c] = 0;
    end
  endtask

  function automatic int remain_at(int c, int tp);
    if (m_act[c]) return m_len0[c] - BEAT * (tp - m_ts[c]);
    return m_rem[c];
  endfunction

  task automatic model_edge(input bit v, input bit we, input logic [31:0] a, input logic [31:0] d,
                            output bit erv, output logic [31:0] erd, output bit eerr, output bit eirq);
    int t, ch, w;
    bit hit, gi, gid, rej;
    t   = m_t;
    ch  = int'(a[9:5]);
    w   = int'(a[4:2]);
    hit = (a[31:10] == 22'd0) && (ch < NUM_CH) && (w <= 5);
    gi  = (a[31:2] == 30'h100);
    gid = (a[31:2] == 30'h101);
    erd = '0;
    rej = 0;
    if (hit) begin
      case (w)
        0: erd = m_src[ch];
        1: erd = m_dst[ch];
        2: erd = 32'(m_len[ch]);
        3: erd = m_ien[ch] ? 32'd4 : 32'd0;
        4: erd = {29'd0, m_errf[ch], m_done[ch], m_act[ch]};
        5: erd = 32'(remain_at(ch, t - 1));
        default: erd = '0;
      endcase
      if (v && we && m_act[ch] && (w <= 2 || (w == 3 && d[0]))) rej = 1;
    end else if (gi) begin
      for (int c = 0; c < NUM_CH; c++) erd[c] = m_done[c] & m_ien[c];
    end else if (gid) begin
      erd = {8'hD0, 8'(NUM_CH), 16'(BEAT)};
    end
    erv  = v && !we;
    eerr = v && (!(hit || gi || gid) || rej);

    if (v && we && hit) begin
      case (w)
        0: if (!m_act[ch]) m_src[ch] = d;
        1: if (!m_act[ch]) m_dst[ch] = d;
        2: if (!m_act[ch]) m_len[ch] = int'(d[LEN_W-1:0]);
        3: begin
          m_ien[ch] = d[2];
          if (m_act[ch] && d[1]) begin
            m_rem[ch]  = remain_at(ch, t - 1);
            m_act[ch]  = 0;
            m_errf[ch] = 1;
          end else if (!m_act[ch] && d[0]) begin
            if (m_len[ch] != 0 && m_src[ch][1:0] == 2'b00 && m_dst[ch][1:0] == 2'b00) begin
              m_act[ch]  = 1;
              m_ts[ch]   = t;
              m_len0[ch] = m_len[ch];
              m_nb[ch]   = (m_len[ch] + BEAT - 1) / BEAT;
              m_done[ch] = 0;
            end else begin
              m_errf[ch] = 1;
            end
          end
        end
        4: begin
          if (d[1]) m_done[ch] = 0;
          if (d[2]) m_errf[ch] = 0;
        end
        default: ;
      endcase
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (m_act[c] && (t - m_ts[c] == m_nb[c])) begin
        m_act[c]  = 0;
        m_done[c] = 1;
        m_rem[c]  = 0;
      end
    end
    eirq = 0;
    for (int c = 0; c < NUM_CH; c++) eirq |= m_done[c] & m_ien[c];
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic step(input bit v, input bit we, input logic [31:0] a, input logic [31:0] d);
    bit          erv, eerr, eirq;
    logic [31:0] erd;
    valid = v; wr_en = we; addr = a; wdata = d;
    @(posedge clk);
    m_t++;
    model_edge(v, we, a, d, erv, erd, eerr, eirq);
    #1;
    chk($sformatf("model_rvalid a=%h", a), 32'(rvalid), 32'(erv));
    chk($sformatf("model_err a=%h", a), 32'(err), 32'(eerr));
    chk($sformatf("model_irq a=%h", a), 32'(irq), 32'(eirq));
    if (erv) chk($sformatf("model_rdata a=%h", a), rdata, erd);
    valid = 0; wr_en = 0;
  endtask

  typedef struct {
    bit          we;
    logic [31:0] a;
    logic [31:0] d;
    bit          rv;
    logic [31:0] rd;
    bit          er;
    bit          iq;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit we, input logic [31:0] a, input logic [31:0] d,
                     input bit rv, input logic [31:0] rd, input bit er, input bit iq);
    vec_t e;
    e.we = we; e.a = a; e.d = d; e.rv = rv; e.rd = rd; e.er = er; e.iq = iq;
    tbl.push_back(e);
  endtask

  initial begin
    // ID, ch1 transfer of 10 bytes, W1C, unmapped and ch0 start errors.
    add(0, 32'h404, 0,       1, 32'hD004_0004, 0, 0);
    add(1, 32'h020, 32'h1000, 0, 0, 0, 0);
    add(1, 32'h024, 32'h2000, 0, 0, 0, 0);
    add(1, 32'h028, 10,      0, 0, 0, 0);
    add(1, 32'h02C, 5,       0, 0, 0, 0);
    add(0, 32'h030, 0,       1, 1, 0, 0);
    add(0, 32'h034, 0,       1, 6, 0, 0);
    add(1, 32'h028, 99,      0, 0, 1, 1);
    add(0, 32'h028, 0,       1, 10, 0, 1);
    add(0, 32'h030, 0,       1, 2, 0, 1);
    add(0, 32'h034, 0,       1, 0, 0, 1);
    add(0, 32'h400, 0,       1, 2, 0, 1);
    add(0, 32'h02C, 0,       1, 4, 0, 1);
    add(1, 32'h030, 2,       0, 0, 0, 0);
    add(0, 32'h030, 0,       1, 0, 0, 0);
    add(0, 32'h0E0, 0,       1, 0, 1, 0);
    add(1, 32'h0E0, 5,       0, 0, 1, 0);
    add(0, 32'h038, 0,       1, 0, 1, 0);
    add(1, 32'h404, 1,       0, 0, 0, 0);
    add(0, 32'h40C, 0,       1, 0, 1, 0);
    add(1, 32'h00C, 1,       0, 0, 0, 0);
    add(0, 32'h010, 0,       1, 4, 0, 0);
    add(1, 32'h010, 4,       0, 0, 0, 0);
    add(0, 32'h010, 0,       1, 0, 0, 0);
    add(1, 32'h008, 8,       0, 0, 0, 0);
    add(1, 32'h000, 32'h1002, 0, 0, 0, 0);
    add(1, 32'h00C, 1,       0, 0, 0, 0);
    add(0, 32'h010, 0,       1, 4, 0, 0);
    add(1, 32'h010, 4,       0, 0, 0, 0);

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_rvalid", 32'(rvalid), 32'h0);
    chk("reset_err", 32'(err), 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    foreach (tbl[i]) begin
      step(1, tbl[i].we, tbl[i].a, tbl[i].d);
      chk($sformatf("tbl%0d_rvalid", i), 32'(rvalid), 32'(tbl[i].rv));
      if (tbl[i].rv) chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].rd);
      chk($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].er));
      chk($sformatf("tbl%0d_irq", i), 32'(irq), 32'(tbl[i].iq));
    end

    // ch2: 64-byte transfer aborted after three beats.
    step(1, 1, 32'h048, 64);
    step(1, 1, 32'h04C, 1);
    repeat (3) step(0, 0, 0, 0);
    step(1, 1, 32'h04C, 2);
    step(1, 0, 32'h054, 0);
    chk("abort_remain", rdata, 32'd52);
    step(1, 0, 32'h050, 0);
    chk("abort_status", rdata, 32'd4);
    chk("abort_irq", 32'(irq), 32'h0);

    // ch3: reset in the middle of a transfer, then a clean restart.
    step(1, 1, 32'h068, 100);
    step(1, 1, 32'h06C, 5);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    reset = 1'b0;
    #2;
    chk("midrst_rvalid", 32'(rvalid), 32'h0);
    chk("midrst_rdata", rdata, 32'h0);
    chk("midrst_err", 32'(err), 32'h0);
    chk("midrst_irq", 32'(irq), 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    step(1, 0, 32'h070, 0);
    chk("postrst_status", rdata, 32'h0);
    step(1, 1, 32'h068, 8);
    step(1, 1, 32'h06C, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 32'h070, 0);
    chk("restart_done", rdata, 32'd2);

    for (int i = 0; i < 600; i++) begin
      int          sel;
      int          c;
      int          w;
      bit          v;
      bit          we;
      logic [31:0] a;
      logic [31:0] d;
      v   = ($urandom_range(0, 99) < 85);
      we  = ($urandom_range(0, 1) == 1);
      sel = $urandom_range(0, 19);
      c   = $urandom_range(0, NUM_CH);
      w   = $urandom_range(0, 6);
      if (sel == 0)      a = 32'h400 | 32'($urandom_range(0, 3));
      else if (sel == 1) a = 32'h404;
      else if (sel == 2) a = $urandom;
      else               a = 32'(c * 32 + w * 4 + $urandom_range(0, 3));
      case (w)
        0, 1: begin
          d = $urandom;
          if ($urandom_range(0, 3) != 0) d[1:0] = 2'b00;
        end
        2: d = 32'($urandom_range(0, 40));
        3: begin
          d = 32'($urandom_range(0, 7));
          if ($urandom_range(0, 3) != 0) d[1] = 1'b0;
        end
        4: d = 32'($urandom_range(0, 7));
        default: d = $urandom;
      endcase
      step(v, we, a, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_reg_bank.md
# dma_reg_bank

Parametrised multi-channel DMA register bank sitting behind the DMA register bus (addr / wr_en / valid / wdata / rdata). It holds per-channel descriptor registers (SRC, DST, LEN, CTRL), runs a per-channel transfer-progress state machine that counts LEN down at a fixed beat rate, and raises a level interrupt on completion. It is the next generation of the single-bus register target: channel count and beat size are configurable, and it adds registered read latency, W1C status, abort and error reporting.

## Interface
- NUM_CH, 4, number of channels (1–16)
- BEAT_BYTES, 4, bytes retired per BUSY cycle (power of two, 1–64)
- LEN_W, 16, width of LEN/REMAIN fields
- clk  input  1  clock; all logic rising-edge
- reset  input  1  asynchronous, active-low reset
- addr  input  32  byte address; bits [1:0] ignored
- wr_en  input  1  1 = write, 0 = read; qualified by valid
- valid  input  1  request strobe, one access per cycle
- wdata  input  32  write data
- rdata  output  32  registered read data
- rvalid  output  1  one-cycle pulse, rdata valid
- err  output  1  one-cycle pulse on unmapped access or rejected write
- irq  output  1  OR of (DONE & IRQ_EN) over all channels

## Operation
- Channel c base = c*0x20. Offsets: 0x00 SRC (RW), 0x04 DST (RW), 0x08 LEN (RW, LEN_W bits, upper read 0), 0x0C CTRL, 0x10 STATUS, 0x14 REMAIN (RO).
- Global: 0x400 IRQ_STATUS (RO, bit c = channel c DONE&IRQ_EN); 0x404 ID (RO) = {8'hD0, 8'(NUM_CH), 16'(BEAT_BYTES)}.
- CTRL: bit0 START (write-1 pulse, reads 0), bit1 ABORT (write-1 pulse, reads 0), bit2 IRQ_EN (RW).
- STATUS: bit0 BUSY (RO), bit1 DONE (W1C), bit2 ERR (W1C).
- Channel FSM IDLE / BUSY:
  - IDLE + START, LEN≠0, SRC[1:0]==DST[1:0]==0: REMAIN←LEN, clear DONE, go BUSY.
  - IDLE + START, otherwise: set ERR, stay IDLE.
  - BUSY each cycle: REMAIN ≤ BEAT_BYTES → REMAIN←0, DONE←1, go IDLE; else REMAIN←REMAIN−BEAT_BYTES.
  - BUSY + ABORT: REMAIN frozen, ERR←1, go IDLE, DONE not set. ABORT in IDLE: no effect.
  - START while BUSY: ignored, err pulse.
- Writes to SRC/DST/LEN while BUSY: ignored, err pulse. Writes to RO registers: ignored, no err.
- Unmapped address (channel index ≥ NUM_CH, offset > 0x14, global other than 0x400/0x404): write dropped, read returns 0; err pulse.
- W1C and hardware set of DONE/ERR in the same cycle: set wins.

## Timing
- Reset (async assert, sync release): rdata=0, rvalid=0, err=0, irq=0; all registers 0; all FSMs IDLE.
- Write sampled at posedge with valid&wr_en; register visible next cycle; START write → BUSY visible the following cycle.
- Read: valid&!wr_en at edge N → rdata/rvalid at edge N+1. Back-to-back reads give one rvalid per cycle.
- err asserts at edge N+1 for offending access at edge N.
- Transfer of LEN bytes occupies ceil(LEN/BEAT_BYTES) BUSY cycles; DONE and irq rise on the edge ending the last BUSY cycle.
- Reset mid-transfer: channel returns to IDLE immediately, no DONE.

## Structure
- Package dma_reg_pkg: offset localparams, CTRL/STATUS bit indices, GLOBAL_BASE, ID constant, ch_state_e enum {IDLE, BUSY}.
- Sub-module dma_reg_channel: one channel's registers + FSM, generated NUM_CH times; top does decode, read mux, rdata/rvalid/err registers and irq OR.

## Test plan
- Reset → rdata=0, irq=0; read 0x404 with NUM_CH=4, BEAT_BYTES=4 → rdata=0xD0040004, rvalid one cycle after request.
- Ch1: SRC=0x1000, DST=0x2000, LEN=10, CTRL=0x5 → BUSY 3 cycles, REMAIN 6, 2, 0; DONE=1, irq=1; write STATUS=0x2 → DONE=0, irq=0.
- Ch0: LEN=0 then START → ERR=1, BUSY never set; SRC=0x1002 then START → ERR=1.
- Ch2: LEN=64, START, ABORT after 3 BUSY cycles → REMAIN=52, ERR=1, DONE=0, irq=0.
- Write LEN while BUSY → err pulse, LEN unchanged; read 0x0E0 with NUM_CH=4 → rdata=0, err pulse.
- Assert reset mid-transfer on ch3 → STATUS reads 0 after release; new START completes normally.
